pair_triple_bist_ctrl: RTL

PAIR_TRIPLE_BIST_CTRL -- requirements
Module: pair_triple_bist_ctrl

---
 rtl/pair_triple_bist_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/pair_triple_bist_ctrl.sv
// pair_triple_bist_ctrl: self-test of a pair/triple (majority) detector over 8 vectors; ports clk rst start det_out -> det_in0..2 busy done pass fail_count first_fail; PAIR_TRIPLE_BIST_SETTLE_EN adds a SETTLE cycle per vector
module pair_triple_bist_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       det_out,
  output logic       det_in0,
  output logic       det_in1,
  output logic       det_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail
);
`ifdef PAIR_TRIPLE_BIST_SETTLE_EN
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [2:0] vec_q, vec_d, first_fail_q, first_fail_d;
  logic [3:0] fail_count_q, fail_count_d;
  logic pass_q, pass_d, expect_v, mism;
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    pass_d = pass_q;
    expect_v = (vec_q[0] & vec_q[1]) | (vec_q[0] & vec_q[2]) | (vec_q[1] & vec_q[2]);
    mism = det_out != expect_v;
    case (state_q)
      IDLE: if (start) begin
        vec_d = 3'd0;
        fail_count_d = 4'd0;
        first_fail_d = 3'd0;
        pass_d = 1'b0;
        state_d = DRIVE;
      end
`ifdef PAIR_TRIPLE_BIST_SETTLE_EN
      DRIVE: state_d = SETTLE;
      SETTLE: state_d = SAMPLE;
`else
      DRIVE: state_d = SAMPLE;
`endif
      SAMPLE: begin
        if (mism && fail_count_q < 4'd8) begin
          fail_count_d = fail_count_q + 4'd1;
          first_fail_d = fail_count_q == 4'd0 ? vec_q : first_fail_q;
        end
        if (vec_q == 3'd7) begin
          state_d = DONE;
          pass_d = fail_count_d == 4'd0;
        end else begin
          vec_d = vec_q + 3'd1;
          state_d = DRIVE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q <= 3'd0;
      fail_count_q <= 4'd0;
      first_fail_q <= 3'd0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      pass_q <= pass_d;
    end
  end
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  assign {det_in2, det_in1, det_in0} = busy ? vec_q : 3'd0;
  assign pass = pass_q;
  assign fail_count = fail_count_q;
  assign first_fail = first_fail_q;
endmodule
